// File: rtl/sub_exerciser.sv
// sub_exerciser: drives fixed and LFSR vectors into an attached
// subtractor and checks each result LAT+1 edges later.
module sub_exerciser #(
    parameter int          WIDTH   = 12,
    parameter int          LAT     = 1,
    parameter int          NUM_VEC = 16,
    parameter logic [11:0] SEED    = 12'hACE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] n1,
    output logic [WIDTH-1:0] n2,
    input  logic [WIDTH:0]   subtract,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [7:0]       first_err_idx
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic           v;
        logic [7:0]     k;
        logic [WIDTH:0] e;
    } ent_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       idx;
    logic [7:0]       nidx;
    logic [11:0]      lfsr;
    logic [11:0]      lfsr_rev;
    logic [WIDTH-1:0] vn1;
    logic [WIDTH-1:0] vn2;
    logic             run_go;
    logic             load;
    logic             chk_bad;
    ent_t             ent_in;
    ent_t             pipe [LAT+1];

    assign run_go  = ((state == IDLE) || (state == DONE)) && start;
    assign load    = (state_nxt == DRIVE);
    assign nidx    = (state == DRIVE) ? idx + 8'd1 : 8'd0;
    assign chk_bad = pipe[LAT].v && (subtract != pipe[LAT].e);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start only honoured when not busy
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = DRIVE;
            DONE:  if (start) state_nxt = DRIVE;
            DRIVE: if (idx == 8'(NUM_VEC - 1)) state_nxt = DRAIN;
            DRAIN: if (idx == 8'(LAT)) state_nxt = DONE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == DRIVE) || (state == DRAIN);
        done = (state == DONE);
        pass = (state == DONE) && (err_count == 8'd0);
    end

    // Bit-reversed LFSR feeds the subtrahend
    always_comb begin
        lfsr_rev = '0;
        for (int i = 0; i < 12; i++) lfsr_rev[i] = lfsr[11-i];
    end

    // Vector about to be driven: fixed corner cases, then LFSR
    always_comb begin
        vn1 = '0;
        vn2 = '0;
        unique case (nidx)
            8'd0: begin vn1 = '0;            vn2 = '0;            end
            8'd1: begin vn1 = WIDTH'(10);    vn2 = WIDTH'(5);     end
            8'd2: begin vn1 = WIDTH'(60);    vn2 = WIDTH'(50);    end
            8'd3: begin vn1 = '0;            vn2 = WIDTH'(4095);  end
            8'd4: begin vn1 = WIDTH'(4095);  vn2 = '0;            end
            default: begin vn1 = WIDTH'(lfsr); vn2 = WIDTH'(lfsr_rev); end
        endcase
        ent_in.v = load;
        ent_in.k = nidx;
        ent_in.e = {1'b0, vn1} - {1'b0, vn2};
    end

    // Operand registers, vector index / drain counter and LFSR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n1   <= '0;
            n2   <= '0;
            idx  <= 8'd0;
            lfsr <= SEED;
        end else begin
            n1 <= load ? vn1 : '0;
            n2 <= load ? vn2 : '0;
            if (load)                idx <= nidx;
            else if (state == DRAIN) idx <= idx + 8'd1;
            else                     idx <= 8'd0;
            if (run_go)
                lfsr <= SEED;
            else if (load && (nidx >= 8'd5))
                lfsr <= {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
        end
    end

    // Expected-value pipeline, valid tag gates every comparison
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= ent_in;
            for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Error counter (saturating) and first failing index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count     <= 8'd0;
            first_err_idx <= 8'hFF;
        end else if (run_go) begin
            err_count     <= 8'd0;
            first_err_idx <= 8'hFF;
        end else if (chk_bad) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (err_count == 8'd0)  first_err_idx <= pipe[LAT].k;
        end
    end

endmodule
